// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit adder split into STAGES registered ripple slices with valid/ready flow control.
// Optional signed-overflow output V is enabled by defining PIPELINED_ADDER_OVF_EN.
module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
`ifdef PIPELINED_ADDER_OVF_EN
    output logic             V,
`endif
    output logic             Cout
);

    localparam int SLICE = WIDTH / STAGES;

    if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_param_err
        $error("pipelined_adder: WIDTH must be a multiple of STAGES with 1 <= STAGES <= WIDTH");
    end

    // One SLICE-bit ripple chain of full-adder cells; returns {carry_out, sum}.
    function automatic logic [SLICE:0] ripple_add(
        input logic [SLICE-1:0] a,
        input logic [SLICE-1:0] b,
        input logic             cin
    );
        logic [SLICE:0]   c;
        logic [SLICE-1:0] s;
        c[0] = cin;
        for (int i = 0; i < SLICE; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        return {c[SLICE], s};
    endfunction

    // The whole pipeline stalls together when the output holds an unconsumed result.
    logic advance_s;
    assign advance_s = !out_valid || out_ready;
    assign in_ready  = advance_s;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int SW = (k + 1) * SLICE;
        localparam int HW = WIDTH - SW;

        logic [SLICE-1:0] a_sl_s;
        logic [SLICE-1:0] b_sl_s;
        logic             cin_s;
        logic             vld_d;
        logic [SLICE:0]   add_s;
        logic [SW-1:0]    sum_d;
        logic [SW-1:0]    sum_q;
        logic             vld_q;
        logic             cry_q;

        assign add_s = ripple_add(a_sl_s, b_sl_s, cin_s);

        if (k == 0) begin : g_src
            assign a_sl_s = A[SLICE-1:0];
            assign b_sl_s = B[SLICE-1:0];
            assign cin_s  = Cin;
            assign vld_d  = in_valid;
            assign sum_d  = add_s[SLICE-1:0];
        end else begin : g_src
            assign a_sl_s = g_stage[k-1].g_skew.a_hi_q[SLICE-1:0];
            assign b_sl_s = g_stage[k-1].g_skew.b_hi_q[SLICE-1:0];
            assign cin_s  = g_stage[k-1].cry_q;
            assign vld_d  = g_stage[k-1].vld_q;
            assign sum_d  = {add_s[SLICE-1:0], g_stage[k-1].sum_q};
        end

        // Slice result, carry to the next slice and valid bit advance together.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= 1'b0;
                cry_q <= 1'b0;
                sum_q <= '0;
            end else if (advance_s) begin
                vld_q <= vld_d;
                cry_q <= add_s[SLICE];
                sum_q <= sum_d;
            end
        end

        if (k < STAGES - 1) begin : g_skew
            logic [HW-1:0] a_hi_d;
            logic [HW-1:0] b_hi_d;
            logic [HW-1:0] a_hi_q;
            logic [HW-1:0] b_hi_q;

            if (k == 0) begin : g_hi_src
                assign a_hi_d = A[WIDTH-1:SLICE];
                assign b_hi_d = B[WIDTH-1:SLICE];
            end else begin : g_hi_src
                assign a_hi_d = g_stage[k-1].g_skew.a_hi_q[HW+SLICE-1:SLICE];
                assign b_hi_d = g_stage[k-1].g_skew.b_hi_q[HW+SLICE-1:SLICE];
            end

            // Upper operand bits wait here until the stage that adds them.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_hi_q <= '0;
                    b_hi_q <= '0;
                end else if (advance_s) begin
                    a_hi_q <= a_hi_d;
                    b_hi_q <= b_hi_d;
                end
            end
        end
    end

    assign S         = g_stage[STAGES-1].sum_q;
    assign Cout      = g_stage[STAGES-1].cry_q;
    assign out_valid = g_stage[STAGES-1].vld_q;

`ifdef PIPELINED_ADDER_OVF_EN
    logic v_d;
    logic v_q;

    // Carry into the MSB is a^b^s at that bit; overflow when it differs from the carry out.
    assign v_d = g_stage[STAGES-1].a_sl_s[SLICE-1] ^ g_stage[STAGES-1].b_sl_s[SLICE-1]
               ^ g_stage[STAGES-1].add_s[SLICE-1] ^ g_stage[STAGES-1].add_s[SLICE];

    // Overflow flag is registered alongside the final sum slice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= 1'b0;
        end else if (advance_s) begin
            v_q <= v_d;
        end
    end

    assign V = v_q;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed self-checking bench for pipelined_adder (WIDTH=32, STAGES=4); checks V when
// PIPELINED_ADDER_OVF_EN is defined.
module tb_pipelined_adder;

    localparam int WIDTH  = 32;
    localparam int STAGES = 4;
`ifdef PIPELINED_ADDER_OVF_EN
    localparam logic [33:0] CMP_MASK = 34'h3_FFFF_FFFF;
`else
    localparam logic [33:0] CMP_MASK = 34'h1_FFFF_FFFF;
`endif

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b1;
    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] A         = 32'h0;
    logic [WIDTH-1:0] B         = 32'h0;
    logic             Cin       = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] S;
    logic             Cout;
`ifdef PIPELINED_ADDER_OVF_EN
    logic             V;
`endif
    logic [33:0]      obs_s;

    int check_cnt = 0;
    int err_cnt   = 0;
    int rcv_cnt   = 0;
    int cyc       = 0;
    logic [33:0] exp_q[$];

    logic [31:0] dir_a [7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000,
                               32'h1234_5678, 32'h00FF_FFFF, 32'h0000_00FF};
    logic [31:0] dir_b [7] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h8000_0000,
                               32'h9ABC_DEF0, 32'h0000_0001, 32'h0000_0000};
    logic        dir_c [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    // Expected {V, Cout, S}
    logic [33:0] dir_e [7] = '{34'h1_0000_0000, 34'h1_FFFF_FFFF, 34'h2_8000_0000, 34'h3_0000_0000,
                               34'h0_ACF1_3568, 34'h0_0100_0000, 34'h0_0000_0100};

    pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
`ifdef PIPELINED_ADDER_OVF_EN
        .V         (V),
`endif
        .Cout      (Cout)
    );

`ifdef PIPELINED_ADDER_OVF_EN
    assign obs_s = {V, Cout, S};
`else
    assign obs_s = {1'b0, Cout, S};
`endif

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        check_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b, input logic cin);
        logic [32:0] sum;
        logic        v;
        sum = {1'b0, a} + {1'b0, b} + {32'd0, cin};
        v   = (a[31] == b[31]) && (sum[31] != a[31]);
        return {v, sum};
    endfunction

    // Consumed results are compared in order against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            check_eq("result_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                check_eq("result", 64'(obs_s & CMP_MASK), 64'(exp_q.pop_front() & CMP_MASK));
                rcv_cnt++;
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic [33:0] exp);
        bit ok = 1'b0;
        A        = a;
        B        = b;
        Cin      = cin;
        in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            @(posedge clk);
            #1;
            exp_q.push_back(exp);
        end else begin
            check_eq("accept_timeout", 64'(in_ready), 64'd1);
        end
    endtask

    task automatic drain(input string tag);
        in_valid = 1'b0;
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        #1;
        check_eq(tag, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic        c;
        int          c0;
        int          r0;

        #1 rst_n = 1'b0;
        #2;
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_sum", 64'(obs_s), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);

        // Latency of a single operand.
        send(32'h0000_0001, 32'h0000_0002, 1'b0, 34'h0_0000_0003);
        in_valid = 1'b0;
        for (int i = 1; i <= STAGES; i++) begin
            @(negedge clk);
            check_eq("latency_out_valid", 64'(out_valid), 64'(i == STAGES));
        end
        drain("latency_drain");

        for (int i = 0; i < 7; i++) send(dir_a[i], dir_b[i], dir_c[i], dir_e[i]);
        drain("directed_drain");

        // Back-to-back streaming.
        c0 = cyc;
        r0 = rcv_cnt;
        for (int i = 0; i < 100; i++) begin
            a = $urandom;
            b = $urandom;
            c = 1'($urandom_range(1, 0));
            send(a, b, c, model(a, b, c));
        end
        check_eq("stream_cycles", 64'(cyc - c0), 64'd100);
        drain("stream_drain");
        check_eq("stream_count", 64'(rcv_cnt - r0), 64'd100);

        // Backpressure with output held for five cycles.
        r0 = rcv_cnt;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    a = $urandom;
                    b = $urandom;
                    c = 1'($urandom_range(1, 0));
                    send(a, b, c, model(a, b, c));
                end
                in_valid = 1'b0;
            end
            begin
                bit          seen;
                logic [33:0] hold;
                seen = 1'b0;
                for (int i = 0; i < 40; i++) begin
                    @(posedge clk);
                    #1;
                    if (out_valid) begin
                        seen = 1'b1;
                        break;
                    end
                end
                check_eq("bp_seen_valid", 64'(seen), 64'd1);
                out_ready = 1'b0;
                hold      = obs_s;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    check_eq("bp_in_ready", 64'(in_ready), 64'd0);
                    check_eq("bp_out_valid", 64'(out_valid), 64'd1);
                    check_eq("bp_hold", 64'(obs_s), 64'(hold));
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain("bp_drain");
        check_eq("bp_count", 64'(rcv_cnt - r0), 64'd8);

        // Asynchronous reset with operands in flight.
        for (int i = 0; i < 5; i++) begin
            a = $urandom;
            b = $urandom;
            send(a, b, 1'b0, model(a, b, 1'b0));
        end
        check_eq("mid_valid_before_rst", 64'(out_valid), 64'd1);
        exp_q.delete();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("mid_rst_sum", 64'(obs_s), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < STAGES + 2; i++) begin
            @(negedge clk);
            check_eq("post_rst_idle", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        r0 = rcv_cnt;
        send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 34'h1_0000_0000);
        drain("post_rst_drain");
        check_eq("post_rst_count", 64'(rcv_cnt - r0), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
        $finish;
    end

endmodule
